// File: rtl/pc_branch_sequencer.sv
// Program-counter sequencer: holds PC, fetches over req/ack, picks next PC per resolved branch.
// Latency: ack -> o_instr_valid 1 cycle; accepted branch -> o_imem_req high at new PC next cycle.
// Backpressure: fetch waits on i_imem_ack; resolution waits on i_br_valid with i_stall low.
//
// Ports:
//   i_clk, i_rst_n           clock, asynchronous active-low reset
//   o_imem_req/o_imem_addr   fetch request (held until i_imem_ack) and address (== PC)
//   i_imem_ack               fetch complete
//   o_instr_valid            one-cycle pulse the cycle after an accepted ack
//   i_br_valid, i_br_kind    resolution strobe; kind 00/11 seq, 01 relative, 10 absolute
//   i_offset_ext             sign-extended byte offset for relative branches
//   i_reg_target             absolute jump target
//   i_stall, i_halt          hold resolution / stop after current instruction
//   o_pc, o_pc_link          current PC and PC + PC_STEP
//   o_halted, o_retired      halted state flag, resolved-instruction count (wraps)
//   o_misalign               sticky misaligned-target flag
// Optional build macro: PC_ALIGN_CHECK_EN enables target alignment checking; without it
// targets are used as-is and o_misalign is tied low.
module pc_branch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  output logic        o_instr_valid,
  input  logic        i_br_valid,
  input  logic [1:0]  i_br_kind,
  input  logic [31:0] i_offset_ext,
  input  logic [31:0] i_reg_target,
  input  logic        i_stall,
  input  logic        i_halt,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_link,
  output logic        o_halted,
  output logic [31:0] o_retired,
  output logic        o_misalign
);

  localparam logic [31:0] STEP = 32'(PC_STEP);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_FETCH  = 2'b01,
    S_EXEC   = 2'b10,
    S_HALTED = 2'b11
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_retired;
  logic        r_imem_req;
  logic        r_instr_valid;
  logic        r_halted;

  logic [31:0] w_seq;
  logic [31:0] w_target;

  // All target arithmetic is modulo 2^32; carries out are simply dropped.
  assign w_seq = r_pc + STEP;

  always_comb begin
    w_target = w_seq;
    case (i_br_kind)
      2'b01:   w_target = w_seq + i_offset_ext;
      2'b10:   w_target = i_reg_target;
      default: w_target = w_seq;
    endcase
  end

`ifdef PC_ALIGN_CHECK_EN
  logic r_misalign;
  assign o_misalign = r_misalign;
`else
  assign o_misalign = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_PC;
      r_retired     <= 32'd0;
      r_imem_req    <= 1'b0;
      r_instr_valid <= 1'b0;
      r_halted      <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
      r_misalign    <= 1'b0;
`endif
    end else begin
      r_instr_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_state    <= S_FETCH;
          r_imem_req <= 1'b1;
        end
        S_FETCH: begin
          if (i_imem_ack) begin
            r_state       <= S_EXEC;
            r_imem_req    <= 1'b0;
            r_instr_valid <= 1'b1;
          end
        end
        S_EXEC: begin
          // Stall freezes everything, including a pending halt.
          if (!i_stall) begin
            if (i_br_valid) begin
`ifdef PC_ALIGN_CHECK_EN
              if (w_target[1:0] != 2'b00) begin
                // Misaligned target: drop the instruction and stop, PC untouched.
                r_misalign <= 1'b1;
                r_halted   <= 1'b1;
                r_state    <= S_HALTED;
              end else
`endif
              begin
                r_pc      <= w_target;
                r_retired <= r_retired + 32'd1;
                if (i_halt) begin
                  r_state  <= S_HALTED;
                  r_halted <= 1'b1;
                end else begin
                  r_state    <= S_FETCH;
                  r_imem_req <= 1'b1;
                end
              end
            end else if (i_halt) begin
              r_state  <= S_HALTED;
              r_halted <= 1'b1;
            end
          end
        end
        S_HALTED: begin
          r_state <= S_HALTED;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_imem_req    = r_imem_req;
  assign o_imem_addr   = r_pc;
  assign o_instr_valid = r_instr_valid;
  assign o_pc          = r_pc;
  assign o_pc_link     = w_seq;
  assign o_halted      = r_halted;
  assign o_retired     = r_retired;

endmodule

// File: tb/tb_pc_branch_sequencer.sv
// Directed bench for pc_branch_sequencer: table of branch vectors plus hand sequences
// for stall, halt, mid-fetch reset and alignment handling.
module tb_pc_branch_sequencer;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic        instr_valid;
  logic        br_valid;
  logic [1:0]  br_kind;
  logic [31:0] offset_ext;
  logic [31:0] reg_target;
  logic        stall;
  logic        halt;
  logic [31:0] pc;
  logic [31:0] pc_link;
  logic        halted;
  logic [31:0] retired;
  logic        misalign;

  int n_cmp = 0;
  int n_bad = 0;

  pc_branch_sequencer #(.RESET_PC(32'h0000_0000), .PC_STEP(4)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .o_imem_req    (imem_req),
    .o_imem_addr   (imem_addr),
    .i_imem_ack    (imem_ack),
    .o_instr_valid (instr_valid),
    .i_br_valid    (br_valid),
    .i_br_kind     (br_kind),
    .i_offset_ext  (offset_ext),
    .i_reg_target  (reg_target),
    .i_stall       (stall),
    .i_halt        (halt),
    .o_pc          (pc),
    .o_pc_link     (pc_link),
    .o_halted      (halted),
    .o_retired     (retired),
    .o_misalign    (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  kind;
    logic [31:0] off;
    logic [31:0] tgt;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vt[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for a fetch, check its address, acknowledge it.
  task automatic fetch_ack(input logic [31:0] exp_addr, input logic [31:0] exp_ret);
    int waited = 0;
    while (imem_req !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    chk("fetch_req_seen", {31'd0, imem_req}, 32'd1);
    chk("imem_addr", imem_addr, exp_addr);
    chk("pc_link", pc_link, exp_addr + 32'd4);
    chk("retired", retired, exp_ret);
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    chk("instr_valid_pulse", {31'd0, instr_valid}, 32'd1);
    chk("req_low_in_exec", {31'd0, imem_req}, 32'd0);
  endtask

  task automatic do_instr(input logic [1:0] kind, input logic [31:0] off, input logic [31:0] tgt,
                          input logic [31:0] exp_addr, input logic [31:0] exp_next,
                          input logic [31:0] exp_ret);
    fetch_ack(exp_addr, exp_ret);
    br_valid   = 1'b1;
    br_kind    = kind;
    offset_ext = off;
    reg_target = tgt;
    tick();
    br_valid = 1'b0;
    chk("next_pc", pc, exp_next);
    chk("req_after_branch", {31'd0, imem_req}, 32'd1);
    chk("instr_valid_one_cycle", {31'd0, instr_valid}, 32'd0);
  endtask

  initial begin
    logic [31:0] cur;
    logic [31:0] ret;

    vt[0] = '{2'b00, 32'h0,         32'h0,         32'h0000_0004};
    vt[1] = '{2'b00, 32'h0,         32'h0,         32'h0000_0008};
    vt[2] = '{2'b10, 32'h0,         32'h0000_0100, 32'h0000_0100};
    vt[3] = '{2'b01, 32'hFFFF_FFF0, 32'h0,         32'h0000_00F4};
    vt[4] = '{2'b11, 32'h1234_0000, 32'h5555_0000, 32'h0000_00F8};
    vt[5] = '{2'b10, 32'h0,         32'hFFFF_FFFC, 32'hFFFF_FFFC};
    vt[6] = '{2'b00, 32'h0,         32'h0,         32'h0000_0000};
    vt[7] = '{2'b01, 32'h0000_0010, 32'h0,         32'h0000_0014};
    vt[8] = '{2'b10, 32'h0,         32'h0000_0040, 32'h0000_0040};

    rst_n = 1'b0; imem_ack = 1'b1; br_valid = 1'b0; br_kind = 2'b00;
    offset_ext = '0; reg_target = '0; stall = 1'b0; halt = 1'b0;

    // Reset state, with a stray ack present.
    tick();
    tick();
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_retired", retired, 32'h0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_misalign", {31'd0, misalign}, 32'd0);
    imem_ack = 1'b0;
    rst_n = 1'b1;
    chk("idle_req", {31'd0, imem_req}, 32'd0);
    tick();
    chk("fetch_after_idle", {31'd0, imem_req}, 32'd1);

    // Table-driven branch vectors.
    cur = 32'h0;
    ret = 32'h0;
    for (int i = 0; i < 9; i++) begin
      do_instr(vt[i].kind, vt[i].off, vt[i].tgt, cur, vt[i].exp_pc, ret);
      cur = vt[i].exp_pc;
      ret = ret + 32'd1;
      chk("retired_inc", retired, ret);
    end

    // Stall holds an absolute jump for 3 cycles.
    fetch_ack(32'h40, ret);
    stall = 1'b1; br_valid = 1'b1; br_kind = 2'b10; reg_target = 32'h2000;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("stall_pc", pc, 32'h40);
      chk("stall_req", {31'd0, imem_req}, 32'd0);
      chk("stall_retired", retired, ret);
    end
    stall = 1'b0;
    tick();
    br_valid = 1'b0;
    ret = ret + 32'd1;
    chk("unstall_pc", pc, 32'h2000);
    chk("unstall_req", {31'd0, imem_req}, 32'd1);
    chk("unstall_retired", retired, ret);

    do_instr(2'b10, 32'h0, 32'h40, 32'h2000, 32'h40, ret);
    ret = ret + 32'd1;

    // Branch and halt together at 0x40.
    fetch_ack(32'h40, ret);
    br_valid = 1'b1; br_kind = 2'b00; halt = 1'b1;
    tick();
    br_valid = 1'b0; halt = 1'b0;
    ret = ret + 32'd1;
    chk("halt_pc", pc, 32'h44);
    chk("halt_flag", {31'd0, halted}, 32'd1);
    chk("halt_retired", retired, ret);
    br_valid = 1'b1; imem_ack = 1'b1; br_kind = 2'b10; reg_target = 32'h800;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("halted_req", {31'd0, imem_req}, 32'd0);
      chk("halted_pc", pc, 32'h44);
      chk("halted_retired", retired, ret);
    end
    br_valid = 1'b0; imem_ack = 1'b0;

    // Reset asserted in the middle of a fetch.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    do_instr(2'b10, 32'h0, 32'h300, 32'h0, 32'h300, 32'h0);
    imem_ack = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("midrst_req", {31'd0, imem_req}, 32'd0);
    chk("midrst_pc", pc, 32'h0);
    chk("midrst_retired", retired, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    imem_ack = 1'b0;
    chk("postrst_req", {31'd0, imem_req}, 32'd1);
    chk("postrst_no_instr", {31'd0, instr_valid}, 32'd0);
    chk("postrst_pc", pc, 32'h0);

    // Halt with no branch: PC and count unchanged.
    fetch_ack(32'h0, 32'h0);
    halt = 1'b1;
    tick();
    halt = 1'b0;
    chk("halt_alone_flag", {31'd0, halted}, 32'd1);
    chk("halt_alone_pc", pc, 32'h0);
    chk("halt_alone_retired", retired, 32'h0);
    tick();
    chk("halt_alone_req", {31'd0, imem_req}, 32'd0);

    // Misaligned absolute target.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    fetch_ack(32'h0, 32'h0);
    br_valid = 1'b1; br_kind = 2'b10; reg_target = 32'h2002;
    tick();
    br_valid = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
    chk("misalign_flag", {31'd0, misalign}, 32'd1);
    chk("misalign_halted", {31'd0, halted}, 32'd1);
    chk("misalign_pc", pc, 32'h0);
    chk("misalign_retired", retired, 32'h0);
    chk("misalign_req", {31'd0, imem_req}, 32'd0);
`else
    chk("unaligned_pc", pc, 32'h2002);
    chk("unaligned_flag", {31'd0, misalign}, 32'd0);
    chk("unaligned_retired", retired, 32'h1);
    chk("unaligned_req", {31'd0, imem_req}, 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
